// File: rtl/conv_loop_controller.sv
// Loop-nest sequencer for the convolution PE: walks y, x, co, ky, kx, ci and
// hands the PE one joint activation/weight transfer per MAC step.
module conv_loop_controller #(
    parameter int FEATURE_MAP_WIDTH  = 64,
    parameter int FEATURE_MAP_HEIGHT = 64,
    parameter int INPUT_NB_CHANNELS  = 4,
    parameter int OUTPUT_NB_CHANNELS = 32,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                                  clk,
    input  logic                                  arst_n_in,
    input  logic                                  start,
    output logic                                  running,
    input  logic                                  a_valid,
    input  logic                                  b_valid,
    output logic                                  a_ready,
    output logic                                  b_ready,
    output logic                                  mac_en,
    output logic                                  acc_clear,
    output logic                                  output_valid,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
    output logic                                  done
);

    localparam int X_W  = $clog2(FEATURE_MAP_WIDTH);
    localparam int Y_W  = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CO_W = $clog2(OUTPUT_NB_CHANNELS);
    // Single-entry loops still need a 1-bit counter that simply stays at 0.
    localparam int CI_W = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
    localparam int K_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    localparam logic [X_W-1:0]  X_LAST  = X_W'(FEATURE_MAP_WIDTH - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [CO_W-1:0] CO_LAST = CO_W'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [CI_W-1:0] CI_LAST = CI_W'(INPUT_NB_CHANNELS - 1);
    localparam logic [K_W-1:0]  K_LAST  = K_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_FIN} state_t;

    state_t state, state_nxt;

    logic [CI_W-1:0] ci_cnt;
    logic [K_W-1:0]  kx_cnt;
    logic [K_W-1:0]  ky_cnt;
    logic [CO_W-1:0] co_cnt;
    logic [X_W-1:0]  x_cnt;
    logic [Y_W-1:0]  y_cnt;

    logic fire;
    logic first_term;
    logic last_term;
    logic last_out;

    logic            pend_vld_p0;
    logic            final_p0;
    logic [X_W-1:0]  pend_x_p0;
    logic [Y_W-1:0]  pend_y_p0;
    logic [CO_W-1:0] pend_ch_p0;

    assign fire       = (state == ST_FETCH) && a_valid && b_valid;
    assign first_term = (ci_cnt == '0) && (kx_cnt == '0) && (ky_cnt == '0);
    assign last_term  = (ci_cnt == CI_LAST) && (kx_cnt == K_LAST) && (ky_cnt == K_LAST);
    assign last_out   = (co_cnt == CO_LAST) && (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        running   = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                running = 1'b1;
                a_ready = 1'b1;
                b_ready = 1'b1;
                if (fire && last_term) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                running   = 1'b1;
                state_nxt = final_p0 ? ST_FIN : ST_FETCH;
            end
            ST_FIN: begin
                running   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Loop nest, innermost ci; each counter carries into the next on wrap.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            ci_cnt <= '0;
            kx_cnt <= '0;
            ky_cnt <= '0;
            co_cnt <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else if (fire) begin
            if (ci_cnt == CI_LAST) begin
                ci_cnt <= '0;
                if (kx_cnt == K_LAST) begin
                    kx_cnt <= '0;
                    if (ky_cnt == K_LAST) begin
                        ky_cnt <= '0;
                        if (co_cnt == CO_LAST) begin
                            co_cnt <= '0;
                            if (x_cnt == X_LAST) begin
                                x_cnt <= '0;
                                if (y_cnt == Y_LAST) y_cnt <= '0;
                                else                 y_cnt <= y_cnt + 1'b1;
                            end else begin
                                x_cnt <= x_cnt + 1'b1;
                            end
                        end else begin
                            co_cnt <= co_cnt + 1'b1;
                        end
                    end else begin
                        ky_cnt <= ky_cnt + 1'b1;
                    end
                end else begin
                    kx_cnt <= kx_cnt + 1'b1;
                end
            end else begin
                ci_cnt <= ci_cnt + 1'b1;
            end
        end
    end

    // Stage p0: MAC strobes for the PE, plus the finished output's coordinates.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            mac_en      <= 1'b0;
            acc_clear   <= 1'b0;
            pend_vld_p0 <= 1'b0;
            final_p0    <= 1'b0;
        end else begin
            mac_en      <= fire;
            acc_clear   <= fire && first_term;
            pend_vld_p0 <= fire && last_term;
            final_p0    <= fire && last_term && last_out;
        end
    end

    always_ff @(posedge clk) begin
        if (fire && last_term) begin
            pend_x_p0  <= x_cnt;
            pend_y_p0  <= y_cnt;
            pend_ch_p0 <= co_cnt;
        end
    end

    // Stage p1: accumulator now holds the last term; coordinates hold between strobes.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            output_valid <= 1'b0;
            output_x     <= '0;
            output_y     <= '0;
            output_ch    <= '0;
            done         <= 1'b0;
        end else begin
            output_valid <= pend_vld_p0;
            if (pend_vld_p0) begin
                output_x  <= pend_x_p0;
                output_y  <= pend_y_p0;
                output_ch <= pend_ch_p0;
            end
            done <= (state == ST_FIN);
        end
    end

endmodule

// File: tb/tb_conv_loop_controller.sv
// Bench for conv_loop_controller: a default-size and a tiny instance run side by
// side against an arithmetic model of the loop nest (transfer count -> terms/coords).
module tb_conv_loop_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n;
    logic st [2];
    logic av [2];
    logic bv [2];

    logic       run0, ar0, br0, mac0, clr0, ov0, done0;
    logic [5:0] ox0, oy0;
    logic [4:0] oc0;
    logic       run1, ar1, br1, mac1, clr1, ov1, done1;
    logic [0:0] ox1, oy1, oc1;

    conv_loop_controller dut0 (
        .clk(clk), .arst_n_in(arst_n), .start(st[0]), .running(run0),
        .a_valid(av[0]), .b_valid(bv[0]), .a_ready(ar0), .b_ready(br0),
        .mac_en(mac0), .acc_clear(clr0), .output_valid(ov0),
        .output_x(ox0), .output_y(oy0), .output_ch(oc0), .done(done0)
    );

    conv_loop_controller #(
        .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .INPUT_NB_CHANNELS(1),
        .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(1)
    ) dut1 (
        .clk(clk), .arst_n_in(arst_n), .start(st[1]), .running(run1),
        .a_valid(av[1]), .b_valid(bv[1]), .a_ready(ar1), .b_ready(br1),
        .mac_en(mac1), .acc_clear(clr1), .output_valid(ov1),
        .output_x(ox1), .output_y(oy1), .output_ch(oc1), .done(done1)
    );

    // Observation vector: 0 running,1 a_ready,2 b_ready,3 mac_en,4 acc_clear,
    // 5 output_valid,6 x,7 y,8 ch,9 done
    logic [31:0] obs   [2][10];
    logic [31:0] exp_v [2][10];
    string names [10] = '{"running", "a_ready", "b_ready", "mac_en", "acc_clear",
                          "output_valid", "output_x", "output_y", "output_ch", "done"};

    always_comb begin
        obs[0] = '{32'(run0), 32'(ar0), 32'(br0), 32'(mac0), 32'(clr0),
                   32'(ov0), 32'(ox0), 32'(oy0), 32'(oc0), 32'(done0)};
        obs[1] = '{32'(run1), 32'(ar1), 32'(br1), 32'(mac1), 32'(clr1),
                   32'(ov1), 32'(ox1), 32'(oy1), 32'(oc1), 32'(done1)};
    end

    int cfg_w  [2] = '{64, 2};
    int cfg_h  [2] = '{64, 2};
    int cfg_ci [2] = '{4, 1};
    int cfg_co [2] = '{32, 2};
    int cfg_k  [2] = '{3, 1};

    // Model: phase 0 idle, 1 fetching, 2 drain, 3 final cycle; n = transfers this layer.
    int ph  [2];
    int n   [2];
    bit p1v [2];
    int p1k [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int first_mac1, last_ov1, done_cyc1, ov_cnt1, noclr1;
    bit trk0;
    int mac_cnt0, clr_cnt0, last_mac0, ov_cyc0, ov_x0, ov_y0, ov_ch0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic model_reset(input int d);
        ph[d]  = 0;
        n[d]   = 0;
        p1v[d] = 1'b0;
        p1k[d] = 0;
        for (int i = 0; i < 10; i++) exp_v[d][i] = '0;
    endtask

    task automatic model_step(input int d);
        int t;
        int outs;
        int k;
        bit xfer;
        t    = cfg_k[d] * cfg_k[d] * cfg_ci[d];
        outs = cfg_w[d] * cfg_h[d] * cfg_co[d];
        xfer = (ph[d] == 1) && av[d] && bv[d];
        exp_v[d][3] = 32'(xfer);
        exp_v[d][4] = 32'(xfer && (n[d] % t == 0));
        exp_v[d][5] = 32'(p1v[d]);
        if (p1v[d]) begin
            k = p1k[d];
            exp_v[d][8] = k % cfg_co[d];
            exp_v[d][6] = (k / cfg_co[d]) % cfg_w[d];
            exp_v[d][7] = k / (cfg_co[d] * cfg_w[d]);
        end
        p1v[d] = xfer && (n[d] % t == t - 1);
        p1k[d] = n[d] / t;
        exp_v[d][9] = 32'(ph[d] == 3);
        case (ph[d])
            0: if (st[d]) begin ph[d] = 1; n[d] = 0; end
            1: if (xfer && (n[d] % t == t - 1)) ph[d] = 2;
            2: ph[d] = (n[d] == outs * t) ? 3 : 1;
            default: ph[d] = 0;
        endcase
        if (xfer) n[d]++;
        exp_v[d][0] = 32'(ph[d] != 0);
        exp_v[d][1] = 32'(ph[d] == 1);
        exp_v[d][2] = 32'(ph[d] == 1);
    endtask

    // Called with inputs already applied just after a falling edge.
    task automatic tick();
        #1;
        if (!arst_n) begin
            model_reset(0);
            model_reset(1);
        end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 10; i++)
                chk($sformatf("d%0d_%s", d, names[i]), obs[d][i], exp_v[d][i]);
        cyc++;
        if (obs[1][3] == 1 && first_mac1 < 0) first_mac1 = cyc;
        if (obs[1][5] == 1) begin ov_cnt1++; last_ov1 = cyc; end
        if (obs[1][9] == 1) done_cyc1 = cyc;
        if (obs[1][3] == 1 && obs[1][4] == 0) noclr1++;
        if (trk0) begin
            if (obs[0][3] == 1) begin
                mac_cnt0++;
                last_mac0 = cyc;
                if (obs[0][4] == 1) clr_cnt0++;
            end
            if (obs[0][5] == 1) begin
                trk0    = 1'b0;
                ov_cyc0 = cyc;
                ov_x0   = int'(obs[0][6]);
                ov_y0   = int'(obs[0][7]);
                ov_ch0  = int'(obs[0][8]);
            end
        end
        if (arst_n) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
    endtask

    task automatic arm0();
        trk0 = 1'b1; mac_cnt0 = 0; clr_cnt0 = 0; last_mac0 = -1;
        ov_cyc0 = -1; ov_x0 = -1; ov_y0 = -1; ov_ch0 = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; av[d] = 1'b1; bv[d] = 1'b1;
            model_reset(d);
        end
        first_mac1 = -1; last_ov1 = -1; done_cyc1 = -1; ov_cnt1 = 0; noclr1 = 0;
        trk0 = 1'b0;
        @(negedge clk);

        // Reset held with both valids high, then idle after release.
        repeat (3) tick();
        arst_n = 1'b1;
        repeat (2) tick();

        // Tiny layer: eight outputs back to back.
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        repeat (25) tick();
        chk("small_strobes", 32'(ov_cnt1), 32'd8);
        chk("small_done_after_strobe", 32'(done_cyc1 - last_ov1), 32'd1);
        chk("small_mac_to_done", 32'(done_cyc1 - first_mac1), 32'd16);
        chk("small_clear_each_mac", 32'(noclr1), 32'd0);

        // Default layer: weight available but activation withheld, then released.
        av[0] = 1'b0; bv[0] = 1'b1; st[0] = 1'b1;
        arm0();
        tick();
        st[0] = 1'b0;
        repeat (10) tick();
        chk("stall_no_mac", 32'(mac_cnt0), 32'd0);
        av[0] = 1'b1;
        for (int i = 0; i < 80 && trk0; i++) tick();
        chk("first_out_timeout", 32'(trk0), 32'd0);
        chk("first_out_macs", 32'(mac_cnt0), 32'd36);
        chk("first_out_clears", 32'(clr_cnt0), 32'd1);
        chk("first_out_latency", 32'(ov_cyc0 - last_mac0), 32'd1);
        chk("first_out_xyz", {8'(ov_x0), 8'(ov_y0), 8'(ov_ch0)}, 24'd0);

        // Random valids on both instances, with start pokes that must be ignored mid-layer.
        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < 2; d++) begin
                av[d] = ($urandom_range(0, 3) != 0);
                bv[d] = ($urandom_range(0, 3) != 0);
                st[d] = ($urandom_range(0, 15) == 0);
            end
            tick();
        end
        st[0] = 1'b0; st[1] = 1'b0;

        // Mid-layer reset after 50 transfers, then a clean restart.
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        tick();
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int i = 0; i < 600 && n[0] < 50; i++) begin
            av[0] = ($urandom_range(0, 2) != 0);
            bv[0] = ($urandom_range(0, 2) != 0);
            tick();
        end
        chk("reach_50_transfers", 32'(n[0]), 32'd50);
        arst_n = 1'b0;
        tick();
        chk("reset_running_low", 32'(run0), 32'd0);
        arst_n = 1'b1;
        tick();
        av[0] = 1'b1; bv[0] = 1'b1; st[0] = 1'b1;
        arm0();
        tick();
        st[0] = 1'b0;
        for (int i = 0; i < 100 && trk0; i++) tick();
        chk("restart_timeout", 32'(trk0), 32'd0);
        chk("restart_xyz", {8'(ov_x0), 8'(ov_y0), 8'(ov_ch0)}, 24'd0);
        chk("restart_macs", 32'(mac_cnt0), 32'd36);
        repeat (100) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_loop_controller.md
Name: conv_loop_controller

Overview:
- Sequencing controller for the convolution datapath of top_system.
- After a start pulse, it walks the full loop nest: output row, output column, output channel, kernel row, kernel column, input channel.
- Jointly accepts one activation word (a) and one weight word (b) per MAC step, and drives MAC enable and accumulator clear to the PE.
- Emits one output-valid strobe with x/y/ch coordinates per completed output; running is high from the accepted start until the last output strobe.

Parameters:
- FEATURE_MAP_WIDTH, 64, output columns (x range 0..W-1)
- FEATURE_MAP_HEIGHT, 64, output rows (y range 0..H-1)
- INPUT_NB_CHANNELS, 4, input channels summed per output
- OUTPUT_NB_CHANNELS, 32, output channels
- KERNEL_SIZE, 3, kernel is KERNEL_SIZE x KERNEL_SIZE

Ports:
- clk  in  1  clock, all state on rising edge
- arst_n_in  in  1  asynchronous active-low reset
- start  in  1  begin a layer; sampled only in IDLE
- running  out  1  layer in progress
- a_valid  in  1  activation word available
- b_valid  in  1  weight word available
- a_ready  out  1  controller accepts activation
- b_ready  out  1  controller accepts weight
- mac_en  out  1  PE performs acc += a*b this cycle
- acc_clear  out  1  with mac_en: acc = a*b (first term of an output)
- output_valid  out  1  accumulator holds a finished output
- output_x  out  $clog2(FEATURE_MAP_WIDTH)  column of finished output
- output_y  out  $clog2(FEATURE_MAP_HEIGHT)  row of finished output
- output_ch  out  $clog2(OUTPUT_NB_CHANNELS)  channel of finished output
- done  out  1  one-cycle pulse after the last output

Behaviour:
- Reset: async assert on arst_n_in=0. State=IDLE, all counters 0, every output 0.
- States:
  - IDLE: start=1 -> FETCH next cycle; running=1 from that cycle.
  - FETCH: a_ready=b_ready=1. Transfer occurs only when a_valid&&b_valid in the same cycle (joint handshake). With only one valid high, no transfer; both readies stay high and nothing is consumed. On a transfer that is the last term of an output -> DRAIN; otherwise stay in FETCH.
  - DRAIN: readies=0 for exactly 1 cycle; then FETCH for the next output, or DONE after the final output.
  - DONE: done=1 and running=0 for 1 cycle; then IDLE.
- Loop order, innermost first: ci (0..CIN-1), kx, ky, co, x, y. Counters wrap to 0 and carry to the next loop.
- Terms per output T = KERNEL_SIZE^2 * INPUT_NB_CHANNELS (36 by default).
- mac_en: registered; high in cycle t+1 for a transfer in cycle t.
- acc_clear: registered with mac_en; high when the transfer was the first term (ci=kx=ky=0).
- output_valid: high for exactly 1 cycle, at t+2 after the last-term transfer at t.
  - output_x/y/ch are held stable on that cycle and carry the coordinates of that output.
  - Between strobes they hold their last value.
- Minimum cycles per output: T transfers + 1 DRAIN cycle. Default layer: 64*64*32 outputs.
- start while not IDLE: ignored.
- Mid-operation reset: immediate return to IDLE with all outputs 0; no pending output_valid survives.
- Readies are not a function of the valids. Valids with readies low are ignored.

Test Plan:
- Reset with a_valid=b_valid=1 held: all outputs 0, running=0, no mac_en.
- Small config W=2,H=2,CIN=1,COUT=2,K=1, valids always 1, start pulse:
  - 8 output_valid pulses, coordinates (x,y,ch) in order (0,0,0),(0,0,1),(1,0,0),(1,0,1),(0,1,0)…(1,1,1).
  - acc_clear with every mac_en; done 1 cycle after the last strobe.
  - 16 cycles from first transfer to done.
- Default config, a_valid held 0 for 10 cycles while b_valid=1: no transfer, no mac_en, b data not consumed. Then a_valid=1: first mac_en with acc_clear=1.
- Default config, single output: exactly 36 mac_en. acc_clear only on the first. output_valid 2 cycles after the 36th transfer, with x=0,y=0,ch=0.
- start pulsed while running: no restart, coordinate sequence unchanged.
- arst_n_in low mid-layer, after 50 transfers: running=0 immediately; after release plus start, the first output_valid reports (0,0,0).
